ulpi_link: RTL and testbench

ULPI link-layer front end between the external ULPI PHY pins and the USB function core (usbf). It owns bus direction and turnaround, and decodes PHY RX CMD bytes into UTMI-style line state and receive strobes. It serialises the core's transmit packets into ULPI TX CMD plus data with STP termination. After reset it performs one ULPI register write to program the PHY Function Control register. `top` instantiates it on the 60 MHz PHY clock and maps its data out/in/oe onto the bidirectional `USB_DATA` pins.

---
 rtl/ulpi_pkg.sv | 35 +++
 rtl/ulpi_rxcmd_decode.sv | 99 +++++++++
 rtl/ulpi_link.sv | 156 +++++++++++++++
 tb/tb_ulpi_link.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ulpi_pkg.sv
// Shared ULPI constants: TX CMD prefixes, PHY register addresses, RX CMD field
// positions and the link FSM state encoding.
package ulpi_pkg;

    localparam logic [1:0] TXCMD_TRANSMIT = 2'b01;
    localparam logic [1:0] TXCMD_REGWRITE = 2'b10;

    localparam logic [5:0] ADDR_FUNC_CTRL = 6'h04;

    localparam int RXCMD_LINE_LSB  = 0;
    localparam int RXCMD_VBUS_LSB  = 2;
    localparam int RXCMD_EVENT_LSB = 4;

    localparam logic [1:0] RXEV_IDLE     = 2'b00;
    localparam logic [1:0] RXEV_ACTIVE   = 2'b01;
    localparam logic [1:0] RXEV_HOSTDISC = 2'b10;
    localparam logic [1:0] RXEV_ERROR    = 2'b11;

    typedef enum logic [3:0] {
        ST_RESET_STP = 4'd0,
        ST_INIT_CMD  = 4'd1,
        ST_INIT_DATA = 4'd2,
        ST_INIT_STP  = 4'd3,
        ST_IDLE      = 4'd4,
        ST_TX_CMD    = 4'd5,
        ST_TX_DATA   = 4'd6,
        ST_TX_STP    = 4'd7,
        ST_RX        = 4'd8
    } link_state_e;

    function automatic logic [7:0] txcmd(input logic [1:0] prefix, input logic [5:0] payload);
        return {prefix, payload};
    endfunction

endpackage

// File: rtl/ulpi_rxcmd_decode.sv
// Registered receive path: bus direction tracking, RX CMD decode and the
// UTMI-style rx_* strobes towards the function core.
module ulpi_rxcmd_decode
    import ulpi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_i,
    output logic       dir_q,
    output logic       dir_rise,
    output logic [1:0] line_state,
    output logic [1:0] vbus_state,
    output logic       rx_active,
    output logic       rx_error,
    output logic       rx_valid,
    output logic [7:0] rx_data
);

    logic       dir_d;
    logic       dir_fall;
    logic [1:0] rx_event;
    logic [1:0] line_state_q, line_state_d;
    logic [1:0] vbus_state_q, vbus_state_d;
    logic       rx_active_q, rx_active_d;
    logic       rx_error_q, rx_error_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;

    assign dir_d    = ulpi_dir;
    assign dir_rise = ulpi_dir & ~dir_q;
    assign dir_fall = ~ulpi_dir & dir_q;
    assign rx_event = ulpi_data_i[RXCMD_EVENT_LSB +: 2];

    always_comb begin
        line_state_d = line_state_q;
        vbus_state_d = vbus_state_q;
        rx_active_d  = rx_active_q;
        rx_error_d   = rx_error_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        if (ulpi_dir && dir_q) begin
            if (ulpi_nxt) begin
                rx_data_d  = ulpi_data_i;
                rx_valid_d = 1'b1;
            end else begin
                line_state_d = ulpi_data_i[RXCMD_LINE_LSB +: 2];
                vbus_state_d = ulpi_data_i[RXCMD_VBUS_LSB +: 2];
                case (rx_event)
                    RXEV_IDLE: begin
                        rx_active_d = 1'b0;
                        rx_error_d  = 1'b0;
                    end
                    RXEV_ACTIVE:   rx_active_d = 1'b1;
                    RXEV_HOSTDISC: rx_active_d = 1'b0;
                    default: begin
                        rx_active_d = 1'b1;
                        rx_error_d  = 1'b1;
                    end
                endcase
            end
        end else if (dir_rise) begin
            if (ulpi_nxt) rx_active_d = 1'b1;
        end else if (dir_fall) begin
            rx_active_d = 1'b0;
            rx_error_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q        <= 1'b0;
            line_state_q <= 2'b00;
            vbus_state_q <= 2'b00;
            rx_active_q  <= 1'b0;
            rx_error_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
        end else begin
            dir_q        <= dir_d;
            line_state_q <= line_state_d;
            vbus_state_q <= vbus_state_d;
            rx_active_q  <= rx_active_d;
            rx_error_q   <= rx_error_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
        end
    end

    // A PHY-initiated receive (dir rising with nxt) is flagged in the turnaround cycle itself.
    assign rx_active  = rx_active_q | (dir_rise & ulpi_nxt);
    assign rx_error   = rx_error_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign line_state = line_state_q;
    assign vbus_state = vbus_state_q;

endmodule

// File: rtl/ulpi_link.sv
// ULPI link front end: PHY Function Control init write, TX CMD/data/STP
// serialisation with PHY preemption, and bus ownership.
//   state      | meaning
//   RESET_STP  | STP held, first cycle out of reset
//   INIT_CMD   | RegWrite command to Function Control
//   INIT_DATA  | Function Control value
//   INIT_STP   | end of register write, init_done set
//   IDLE       | link owns bus, drives NOOP
//   TX_CMD     | Transmit TX CMD carrying the PID
//   TX_DATA    | packet payload bytes
//   TX_STP     | end of packet
//   RX         | PHY owns the bus
module ulpi_link
    import ulpi_pkg::*;
#(
    parameter logic [7:0] FUNC_CTRL_VAL = 8'h45
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    output logic       ulpi_stp,
    output logic       init_done,
    output logic [1:0] line_state,
    output logic [1:0] vbus_state,
    output logic       rx_active,
    output logic       rx_error,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_abort
);

    link_state_e state_q, state_d;
    logic        init_done_q, init_done_d;
    logic        dir_q;
    logic        dir_rise;
    logic        bus_free;
    logic        drive;

    ulpi_rxcmd_decode u_rx (
        .clk         (clk),
        .rst         (rst),
        .ulpi_dir    (ulpi_dir),
        .ulpi_nxt    (ulpi_nxt),
        .ulpi_data_i (ulpi_data_i),
        .dir_q       (dir_q),
        .dir_rise    (dir_rise),
        .line_state  (line_state),
        .vbus_state  (vbus_state),
        .rx_active   (rx_active),
        .rx_error    (rx_error),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data)
    );

    assign bus_free = ~ulpi_dir & ~dir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RESET_STP;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_RESET_STP: state_d = ST_INIT_CMD;
            // nxt only counts as an accept while the link owns the bus.
            ST_INIT_CMD:  if (bus_free && ulpi_nxt) state_d = ST_INIT_DATA;
            ST_INIT_DATA: begin
                if (ulpi_dir)      state_d = ST_INIT_CMD;
                else if (ulpi_nxt) state_d = ST_INIT_STP;
            end
            ST_INIT_STP: begin
                if (ulpi_dir) begin
                    state_d = ST_INIT_CMD;
                end else begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (ulpi_dir)                                  state_d = ST_RX;
                else if (tx_valid && init_done_q && bus_free) state_d = ST_TX_CMD;
            end
            ST_TX_CMD: begin
                if (ulpi_dir)      state_d = ST_RX;
                else if (ulpi_nxt) state_d = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                if (ulpi_dir)       state_d = ST_RX;
                else if (!tx_valid) state_d = ST_TX_STP;
            end
            ST_TX_STP: state_d = ulpi_dir ? ST_RX : ST_IDLE;
            ST_RX:     if (bus_free) state_d = ST_IDLE;
            default:   state_d = ST_RESET_STP;
        endcase
    end

    always_comb begin
        drive       = 1'b0;
        ulpi_data_o = 8'h00;
        ulpi_stp    = 1'b0;
        tx_ready    = 1'b0;
        tx_abort    = 1'b0;
        case (state_q)
            ST_RESET_STP: ulpi_stp = 1'b1;
            ST_INIT_CMD: begin
                drive       = 1'b1;
                ulpi_data_o = txcmd(TXCMD_REGWRITE, ADDR_FUNC_CTRL);
            end
            ST_INIT_DATA: begin
                drive       = 1'b1;
                ulpi_data_o = FUNC_CTRL_VAL;
            end
            ST_INIT_STP: begin
                drive    = 1'b1;
                ulpi_stp = ~ulpi_dir;
            end
            ST_IDLE: drive = 1'b1;
            ST_TX_CMD: begin
                drive       = 1'b1;
                ulpi_data_o = txcmd(TXCMD_TRANSMIT, {2'b00, tx_data[3:0]});
                tx_ready    = ulpi_nxt & ~ulpi_dir;
                tx_abort    = dir_rise;
            end
            ST_TX_DATA: begin
                drive       = 1'b1;
                ulpi_data_o = tx_data;
                tx_ready    = ulpi_nxt & ~ulpi_dir;
                tx_abort    = dir_rise;
            end
            ST_TX_STP: begin
                drive    = 1'b1;
                ulpi_stp = ~ulpi_dir;
                tx_abort = dir_rise;
            end
            default: ;
        endcase
    end

    assign ulpi_data_oe = drive & ~ulpi_dir & ~dir_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_ulpi_link.sv
// Bench for ulpi_link: the bench plays PHY and function core; expected bus and
// receive bytes go through queues and are popped as the DUT produces them.
module tb_ulpi_link;

    localparam logic [7:0] FUNC = 8'h45;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ulpi_dir = 1'b0;
    logic       ulpi_nxt = 1'b0;
    logic [7:0] ulpi_data_i = 8'h00;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe;
    logic       ulpi_stp;
    logic       init_done;
    logic [1:0] line_state;
    logic [1:0] vbus_state;
    logic       rx_active;
    logic       rx_error;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       tx_abort;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] bus_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] core_q[$];

    always #5 clk = ~clk;

    ulpi_link #(.FUNC_CTRL_VAL(FUNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_data_i  (ulpi_data_i),
        .ulpi_data_o  (ulpi_data_o),
        .ulpi_data_oe (ulpi_data_oe),
        .ulpi_stp     (ulpi_stp),
        .init_done    (init_done),
        .line_state   (line_state),
        .vbus_state   (vbus_state),
        .rx_active    (rx_active),
        .rx_error     (rx_error),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .tx_abort     (tx_abort)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_core();
        tx_valid = (core_q.size() != 0);
        tx_data  = tx_valid ? core_q[0] : 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; ulpi_dir = 1'b0; ulpi_nxt = 1'b0; ulpi_data_i = 8'h00;
        tx_valid = 1'b0; tx_data = 8'h00;
        repeat (3) step();
        n_cmp++;
        if ({ulpi_stp, ulpi_data_oe, ulpi_data_o, init_done, line_state, vbus_state,
             rx_active, rx_error, rx_valid, rx_data, tx_ready, tx_abort} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: stp=%b oe=%b data_o=%h init_done=%b ls=%b vb=%b act=%b err=%b vld=%b rxd=%h rdy=%b abort=%b, required stp=1 and all others 0",
                     ulpi_stp, ulpi_data_oe, ulpi_data_o, init_done, line_state, vbus_state,
                     rx_active, rx_error, rx_valid, rx_data, tx_ready, tx_abort);
        end
    endtask

    // Releases reset and plays the PHY side of the Function Control write.
    task automatic run_init(input string tag);
        logic [7:0] e;
        bus_q.delete();
        bus_q.push_back(8'h84);
        bus_q.push_back(FUNC);
        ulpi_nxt = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 20 && bus_q.size() != 0; i++) begin
            step();
            if (ulpi_data_oe && !ulpi_stp && ulpi_data_o != 8'h00) begin
                e = bus_q.pop_front();
                n_cmp++;
                if (ulpi_data_o !== e) begin
                    n_err++;
                    $display("FAIL %s_regwrite_byte: bus=%h required=%h", tag, ulpi_data_o, e);
                end
                ulpi_nxt = 1'b1;
            end else begin
                ulpi_nxt = 1'b0;
            end
        end
        n_cmp++;
        if (bus_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_timeout: %0d register-write bytes never seen, required 0", tag, bus_q.size());
        end
        step();
        ulpi_nxt = 1'b0;
        #1;
        n_cmp++;
        if ({ulpi_stp, ulpi_data_oe, ulpi_data_o} !== {1'b1, 1'b1, 8'h00}) begin
            n_err++;
            $display("FAIL %s_stp: stp=%b oe=%b data=%h required stp=1 oe=1 data=00", tag, ulpi_stp, ulpi_data_oe, ulpi_data_o);
        end
        step();
        n_cmp++;
        if ({ulpi_stp, init_done} !== 2'b01) begin
            n_err++;
            $display("FAIL %s_done: stp=%b init_done=%b required stp=0 init_done=1", tag, ulpi_stp, init_done);
        end
    endtask

    task automatic test_init();
        run_init("init");
    endtask

    task automatic test_rx();
        bit         dir_t[6] = '{1, 1, 1, 0, 0, 0};
        bit         nxt_t[6] = '{1, 1, 1, 0, 0, 0};
        logic [7:0] dat_t[6] = '{8'h00, 8'hC3, 8'h11, 8'h00, 8'h00, 8'h00};
        logic [7:0] e;
        int nv = 0;
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            step();
            ulpi_dir = dir_t[i]; ulpi_nxt = nxt_t[i]; ulpi_data_i = dat_t[i];
            if (i > 0 && dir_t[i] && dir_t[i-1] && nxt_t[i]) rx_q.push_back(dat_t[i]);
            #1;
            if (rx_valid) begin
                nv++;
                n_cmp++;
                if (rx_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rx_unexpected: rx_valid with %h, required no strobe", rx_data);
                end else begin
                    e = rx_q.pop_front();
                    if (rx_data !== e) begin
                        n_err++;
                        $display("FAIL rx_data: got %h required %h", rx_data, e);
                    end
                end
            end
            if (i == 0) begin
                n_cmp++;
                if ({rx_active, ulpi_data_oe} !== 2'b10) begin
                    n_err++;
                    $display("FAIL rx_turnaround: rx_active=%b oe=%b required 1/0", rx_active, ulpi_data_oe);
                end
            end
            if (i == 4) begin
                n_cmp++;
                if (rx_active !== 1'b0) begin
                    n_err++;
                    $display("FAIL rx_end: rx_active=%b required 0", rx_active);
                end
            end
        end
        n_cmp++;
        if (nv != 2 || rx_q.size() != 0) begin
            n_err++;
            $display("FAIL rx_count: strobes=%0d pending=%0d required 2/0", nv, rx_q.size());
        end
    endtask

    task automatic test_rxcmd();
        bit         dir_t[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [7:0] dat_t[8] = '{8'h3F, 8'h31, 8'h0E, 8'h35, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [5:0] want;
        logic [5:0] got;
        ulpi_nxt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            ulpi_dir = dir_t[i]; ulpi_data_i = dat_t[i];
            #1;
            got = {line_state, vbus_state, rx_active, rx_error};
            case (i)
                1: want = {got[5:2], 2'b00};
                2: want = {2'b01, 2'b00, 1'b1, 1'b1};
                3: want = {2'b10, 2'b11, 1'b0, 1'b0};
                4: want = {2'b01, 2'b01, 1'b1, 1'b1};
                5: want = {got[5:2], 2'b00};
                default: want = got;
            endcase
            if (i >= 1 && i <= 5) begin
                n_cmp++;
                if (got !== want) begin
                    n_err++;
                    $display("FAIL rxcmd_%0d: ls/vb/act/err=%b required %b", i, got, want);
                end
            end
        end
    endtask

    task automatic test_tx();
        bit nxt_t[8] = '{0, 0, 1, 0, 1, 0, 0, 0};
        logic [7:0] e;
        int hs = 0;
        int stp_n = 0;
        core_q = '{8'h4B, 8'h12};
        bus_q  = '{8'h4B, 8'h12};
        for (int i = 0; i < 8; i++) begin
            step();
            drive_core();
            ulpi_nxt = nxt_t[i];
            #1;
            if (ulpi_stp) begin
                stp_n++;
                n_cmp++;
                if ({ulpi_data_oe, ulpi_data_o} !== {1'b1, 8'h00}) begin
                    n_err++;
                    $display("FAIL tx_stp: oe=%b data=%h required 1/00", ulpi_data_oe, ulpi_data_o);
                end
            end else if (i >= 1 && bus_q.size() != 0) begin
                n_cmp++;
                if (!ulpi_data_oe || ulpi_data_o !== bus_q[0]) begin
                    n_err++;
                    $display("FAIL tx_bus_%0d: oe=%b data=%h required oe=1 data=%h", i, ulpi_data_oe, ulpi_data_o, bus_q[0]);
                end
                if (ulpi_nxt) e = bus_q.pop_front();
            end
            if (tx_valid && tx_ready) begin
                hs++;
                e = core_q.pop_front();
            end
            if (i == 7) begin
                n_cmp++;
                if ({ulpi_stp, ulpi_data_oe, ulpi_data_o} !== {1'b0, 1'b1, 8'h00}) begin
                    n_err++;
                    $display("FAIL tx_idle: stp=%b oe=%b data=%h required 0/1/00", ulpi_stp, ulpi_data_oe, ulpi_data_o);
                end
            end
        end
        drive_core();
        n_cmp++;
        if (hs != 2 || stp_n != 1 || bus_q.size() != 0) begin
            n_err++;
            $display("FAIL tx_summary: handshakes=%0d stp_cycles=%0d bus_pending=%0d required 2/1/0", hs, stp_n, bus_q.size());
        end
    endtask

    task automatic test_abort();
        bit dir_t[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        bit nxt_t[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
        logic [7:0] e;
        int hs = 0;
        int ab = 0;
        int stp_n = 0;
        core_q = '{8'hC3, 8'hAA, 8'hBB};
        for (int i = 0; i < 8; i++) begin
            step();
            drive_core();
            ulpi_dir = dir_t[i]; ulpi_nxt = nxt_t[i];
            #1;
            if (tx_abort) begin
                ab++;
                core_q.delete();
            end
            if (ulpi_stp) stp_n++;
            if (tx_valid && tx_ready) begin
                hs++;
                e = core_q.pop_front();
            end
            if (i == 1) begin
                n_cmp++;
                if (ulpi_data_o !== 8'h43) begin
                    n_err++;
                    $display("FAIL abort_txcmd: data=%h required 43", ulpi_data_o);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if ({ulpi_data_oe, ulpi_data_o} !== {1'b1, 8'hAA}) begin
                    n_err++;
                    $display("FAIL abort_txdata: oe=%b data=%h required 1/AA", ulpi_data_oe, ulpi_data_o);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if ({ulpi_data_oe, tx_abort, ulpi_stp} !== 3'b010) begin
                    n_err++;
                    $display("FAIL abort_edge: oe=%b abort=%b stp=%b required 0/1/0", ulpi_data_oe, tx_abort, ulpi_stp);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if ({ulpi_data_oe, ulpi_data_o} !== {1'b1, 8'h00}) begin
                    n_err++;
                    $display("FAIL abort_idle: oe=%b data=%h required 1/00", ulpi_data_oe, ulpi_data_o);
                end
            end
        end
        drive_core();
        n_cmp++;
        if (ab != 1 || stp_n != 0 || hs != 1) begin
            n_err++;
            $display("FAIL abort_summary: aborts=%0d stp_cycles=%0d handshakes=%0d required 1/0/1", ab, stp_n, hs);
        end
    endtask

    task automatic test_tx_vs_rx();
        bit dir_t[6] = '{1, 1, 1, 0, 0, 0};
        int bad = 0;
        ulpi_nxt = 1'b0;
        core_q = '{8'h4B};
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 3) core_q.delete();
            drive_core();
            ulpi_dir = dir_t[i];
            #1;
            if (tx_ready || tx_abort || (i < 3 && ulpi_data_oe)) bad++;
            if (i == 5) begin
                n_cmp++;
                if ({ulpi_data_oe, ulpi_data_o} !== {1'b1, 8'h00}) begin
                    n_err++;
                    $display("FAIL rx_wins_idle: oe=%b data=%h required 1/00", ulpi_data_oe, ulpi_data_o);
                end
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rx_wins: %0d cycles with ready/abort/drive, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] e;
        core_q = '{8'h4B, 8'h12};
        for (int i = 0; i < 4; i++) begin
            step();
            drive_core();
            ulpi_nxt = (i == 2);
            #1;
            if (tx_valid && tx_ready) e = core_q.pop_front();
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ulpi_stp, ulpi_data_oe, ulpi_data_o, init_done, tx_ready} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL midtx_reset: stp=%b oe=%b data=%h init_done=%b rdy=%b required 1/0/00/0/0",
                     ulpi_stp, ulpi_data_oe, ulpi_data_o, init_done, tx_ready);
        end
        core_q.delete();
        drive_core();
        ulpi_nxt = 1'b0;
        repeat (2) step();
        run_init("reinit");
    endtask

    initial begin
        test_reset();
        test_init();
        test_rx();
        test_rxcmd();
        test_tx();
        test_abort();
        test_tx_vs_rx();
        test_reset_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
